imem_loader: RTL and testbench

- Boot-time writer for the instruction memory byte storage that the IFU reads.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload bytes sequentially from byte address 0 through a byte write port.
- Verifies an XOR checksum and holds the processor stalled (cpu_hold) until a good image is loaded.
- Sits between the external debug/UART byte source and the imem write port. It is the synthesizable replacement for loading the memory from a file.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 99 +++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time instruction memory loader:
// frame start marker and the 3-bit FSM state encodings.
package imem_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  localparam logic [2:0] LOADER_ST_IDLE  = 3'd0;
  localparam logic [2:0] LOADER_ST_LEN_H = 3'd1;
  localparam logic [2:0] LOADER_ST_LEN_L = 3'd2;
  localparam logic [2:0] LOADER_ST_DATA  = 3'd3;
  localparam logic [2:0] LOADER_ST_CHECK = 3'd4;
  localparam logic [2:0] LOADER_ST_DONE  = 3'd5;
  localparam logic [2:0] LOADER_ST_ERR   = 3'd6;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus the imem byte write port of the loader.
// The loader is the slave; the byte source / imem side is the master.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_ready;

  modport master (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Parses SYNC/LEN_HI/LEN_LO/payload/CHK frames, writes the payload into imem
// from address 0 and releases cpu_hold only after a checksum-correct image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE  = LOADER_SYNC
) (
  input  logic          clk,
  input  logic          reset_n,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

  logic [2:0]            state;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   cnt;
  logic [7:0]            chk;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  logic                  xfer;
  logic                  last_byte;
  logic [15:0]           len_next;

  // A stalled write blocks the stream, so at most one write is ever pending.
  assign bus.in_ready  = ~mem_we | bus.mem_ready;
  assign xfer          = bus.in_valid & bus.in_ready;
  assign len_next      = {len[15:8], bus.in_data};
  assign last_byte     = (32'(cnt) + 32'd1) == 32'(len);

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign done          = (state == LOADER_ST_DONE);
  assign error         = (state == LOADER_ST_ERR);
  assign cpu_hold      = (state != LOADER_ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= LOADER_ST_IDLE;
      len   <= '0;
      cnt   <= '0;
      chk   <= '0;
    end else if (xfer) begin
      case (state)
        LOADER_ST_IDLE, LOADER_ST_DONE, LOADER_ST_ERR: begin
          if (bus.in_data == SYNC_BYTE) state <= LOADER_ST_LEN_H;
        end
        LOADER_ST_LEN_H: begin
          len   <= {bus.in_data, 8'h00};
          state <= LOADER_ST_LEN_L;
        end
        LOADER_ST_LEN_L: begin
          len <= len_next;
          cnt <= '0;
          chk <= '0;
          if (32'(len_next) > CAP)  state <= LOADER_ST_ERR;
          else if (len_next == '0)  state <= LOADER_ST_CHECK;
          else                      state <= LOADER_ST_DATA;
        end
        LOADER_ST_DATA: begin
          chk <= chk ^ bus.in_data;
          cnt <= cnt + 1'b1;
          if (last_byte) state <= LOADER_ST_CHECK;
        end
        LOADER_ST_CHECK: begin
          state <= (bus.in_data == chk) ? LOADER_ST_DONE : LOADER_ST_ERR;
        end
        default: state <= LOADER_ST_IDLE;
      endcase
    end
  end

  // Write register: held until imem samples it with mem_ready high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (mem_we && bus.mem_ready) mem_we <= 1'b0;
      // NOTE: non-blocking assignments, so a DATA transfer in the completion
      // cycle overrides the clear above and keeps mem_we high with new data.
      if (xfer && state == LOADER_ST_DATA) begin
        mem_we    <= 1'b1;
        mem_addr  <= cnt[ADDR_WIDTH-1:0];
        mem_wdata <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level model of the loader.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  logic cpu_hold, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus();

  imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+7:0] act_q[$];
  logic [7:0]    shadow[CAP];
  bit            rdy_random = 1'b0;
  bit            gaps       = 1'b0;
  int            stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  int            we_a1      = 0;
  int            nrdy       = 0;
  bit            exp_done   = 1'b0;
  bit            exp_error  = 1'b0;

  logic [7:0] g[$];
  logic [7:0] p[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // imem side: drive mem_ready, then log completed writes mid-cycle.
  always @(negedge clk) begin
    if (stall_left > 0 && bus.mem_we && bus.mem_addr == stall_addr) begin
      bus.mem_ready = 1'b0;
      stall_left--;
    end else begin
      bus.mem_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (reset_n && bus.mem_we && bus.mem_ready) begin
      act_q.push_back({bus.mem_addr, bus.mem_wdata});
      shadow[bus.mem_addr] = bus.mem_wdata;
    end
    if (bus.mem_we && bus.mem_addr == AW'(1)) we_a1++;
    if (!bus.in_ready) nrdy++;
  end

  // Presents one byte and returns just before the edge that transfers it.
  task automatic put_byte(input logic [7:0] b);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #2;
    budget = 0;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (budget >= 200) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Frame-level model: payload lands at addresses 0..len-1, status follows
  // the XOR checksum, oversize lengths are rejected right after the length.
  task automatic send_frame(input string tag, input logic [7:0] garb[$], input int len,
                            input logic [7:0] pay[$], input logic [7:0] chk_byte);
    logic [7:0]    x = 8'h00;
    logic [AW+7:0] exp_q[$];
    logic [15:0]   l16 = 16'(len);
    act_q.delete();
    we_a1 = 0;
    nrdy  = 0;
    foreach (garb[i]) put_byte(garb[i]);
    put_byte(8'hA5);
    put_byte(l16[15:8]);
    put_byte(l16[7:0]);
    if (len > CAP) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
    end else begin
      foreach (pay[i]) begin
        x ^= pay[i];
        exp_q.push_back({AW'(i), pay[i]});
        put_byte(pay[i]);
      end
      put_byte(chk_byte);
      exp_done  = (chk_byte == x);
      exp_error = !exp_done;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    check({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
    check({tag, "_error"}, {31'd0, error},    {31'd0, exp_error});
    check({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, !exp_done});
    check({tag, "_nwr"},   act_q.size(),      exp_q.size());
    foreach (exp_q[i])
      if (i < act_q.size()) check({tag, "_wr"}, 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] r = 8'h00;
    foreach (q[i]) r ^= q[i];
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    logic [7:0] b, c;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check("rst_hold",     {31'd0, cpu_hold},     32'd1);
    check("rst_done",     {31'd0, done},         32'd0);
    check("rst_error",    {31'd0, error},        32'd0);
    check("rst_we",       {31'd0, bus.mem_we},   32'd0);
    check("rst_addr",     32'(bus.mem_addr),     32'd0);
    check("rst_wdata",    32'(bus.mem_wdata),    32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset_n = 1'b1;

    // Basic 4-byte image at full throughput.
    g.delete();
    p = {8'h11, 8'h22, 8'h33, 8'h44};
    send_frame("basic", g, 4, p, xor_of(p));
    check("basic_single_cycle", we_a1, 1);
    foreach (p[i]) check("basic_imem", 32'(shadow[i]), 32'(p[i]));

    // Same image with the second write stalled three cycles.
    stall_addr = AW'(1);
    stall_left = 3;
    send_frame("stall", g, 4, p, xor_of(p));
    check("stall_we_cycles",  we_a1, 4);
    check("stall_in_ready_0", nrdy,  3);

    // Bad checksum, then retry with the correct one.
    p = {8'hF0, 8'h0F};
    send_frame("badchk", g, 2, p, 8'h00);
    send_frame("retry",  g, 2, p, 8'hFF);

    // Garbage ahead of a zero-length image.
    g = {8'h00, 8'h13, 8'hFF};
    p.delete();
    send_frame("garbage", g, 0, p, 8'h00);

    // Oversize length is rejected right after LEN_LO.
    g.delete();
    send_frame("oversize", g, CAP + 1, p, 8'h00);

    // Reset in the middle of the payload.
    put_byte(8'hA5);
    put_byte(8'h00);
    put_byte(8'h04);
    put_byte(8'h11);
    put_byte(8'h22);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    #2;
    check("midrst_we",    {31'd0, bus.mem_we}, 32'd0);
    check("midrst_hold",  {31'd0, cpu_hold},   32'd1);
    check("midrst_done",  {31'd0, done},       32'd0);
    check("midrst_error", {31'd0, error},      32'd0);
    reset_n = 1'b1;
    p = {8'h5A, 8'hC3, 8'h7E, 8'h01};
    send_frame("after_rst", g, 4, p, xor_of(p));

    // Randomized frames with bubbles on both handshakes.
    gaps       = 1'b1;
    rdy_random = 1'b1;
    for (int k = 0; k < 25; k++) begin
      g.delete();
      p.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        g.push_back(b);
      end
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(CAP + 1, 3000);
      end else begin
        len = $urandom_range(0, 24);
        repeat (len) p.push_back(8'($urandom_range(0, 255)));
      end
      c = xor_of(p);
      if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
      send_frame("rand", g, len, p, c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Full-capacity image: last write lands at address CAP-1.
    g.delete();
    p.delete();
    repeat (CAP) p.push_back(8'($urandom_range(0, 255)));
    send_frame("full", g, CAP, p, xor_of(p));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
